alu_reservation_station: RTL and testbench

Reservation station directly upstream of the integer ALU. Accepts dispatched ALU/branch micro-ops from the issue stage, holds them until both operands are available, snoops the two common data bus (CDB) broadcasts for missing operands, and issues one ready micro-op per cycle onto the ALU operand/op/tag inputs. ROB tag 0 is reserved for "no producer / nothing" throughout, matching the ALU's convention that destination 0 means do nothing.

---
 rtl/alu_reservation_station_pkg.sv | 25 ++
 rtl/alu_reservation_station_rs_select.sv | 23 ++
 rtl/alu_reservation_station.sv | 171 +++++++++++++++++
 tb/tb_alu_reservation_station.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_reservation_station_pkg.sv
// Shared definitions for the ALU reservation station: opcodes, tag defaults.
package alu_reservation_station_pkg;

  localparam int TAG_W  = 3;
  localparam int NO_TAG = 0;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;
  localparam logic [4:0] OP_EQ   = 5'd10;
  localparam logic [4:0] OP_NE   = 5'd11;
  localparam logic [4:0] OP_LT   = 5'd12;
  localparam logic [4:0] OP_GE   = 5'd13;
  localparam logic [4:0] OP_LTU  = 5'd14;
  localparam logic [4:0] OP_JALR = 5'd16;
  localparam logic [4:0] IDLE_OP = 5'b11111;

endpackage

// File: rtl/alu_reservation_station_rs_select.sv
// Find-first-set: lowest set request index plus an any-found flag.
module rs_select #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  // Scan from the top down so the lowest set index is the one that sticks.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station feeding the integer ALU: holds micro-ops until both
// operands are known, snoops two CDBs, issues one ready op per cycle.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = alu_reservation_station_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             disp_valid,
  input  logic [4:0]       disp_op,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic [TAG_W-1:0] disp_des,
  input  logic             disp_is_branch,
  output logic             full,
  input  logic [TAG_W-1:0] cdb0_des,
  input  logic [TAG_W-1:0] cdb1_des,
  input  logic [31:0]      cdb0_val,
  input  logic [31:0]      cdb1_val,
  output logic [31:0]      alu_value_1,
  output logic [31:0]      alu_value_2,
  output logic [4:0]       alu_op,
  output logic [TAG_W-1:0] alu_des,
  output logic             alu_is_branch
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TAG_W-1:0] NO_Q = TAG_W'(NO_TAG);

  typedef struct packed {
    logic             busy;
    logic [4:0]       op;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [TAG_W-1:0] des;
    logic             is_branch;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [DEPTH-1:0] busy_vec, ready_vec;
  logic [IDX_W-1:0] free_idx, rdy_idx;
  logic             free_found, rdy_found;

  logic [31:0]      alu_v1_q, alu_v1_d, alu_v2_q, alu_v2_d;
  logic [4:0]       alu_op_q, alu_op_d;
  logic [TAG_W-1:0] alu_des_q, alu_des_d;
  logic             alu_br_q, alu_br_d;

  // Busy/ready vectors come from registered state only, so a capture is
  // visible one edge later and a freed slot is reusable one edge later.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy && (ent_q[i].qj == NO_Q) && (ent_q[i].qk == NO_Q);
    end
  end

  rs_select #(.N(DEPTH)) u_free_pick (
    .req_i   (~busy_vec),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  rs_select #(.N(DEPTH)) u_ready_pick (
    .req_i   (ready_vec),
    .idx_o   (rdy_idx),
    .found_o (rdy_found)
  );

  assign full = &busy_vec;

  // Next-state for entries (snoop, issue, dispatch) and the ALU output regs.
  always_comb begin
    entry_t new_e;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy && ent_q[i].qj != NO_Q) begin
        if (ent_q[i].qj == cdb0_des) begin
          ent_d[i].vj = cdb0_val; ent_d[i].qj = NO_Q;
        end else if (ent_q[i].qj == cdb1_des) begin
          ent_d[i].vj = cdb1_val; ent_d[i].qj = NO_Q;
        end
      end
      if (ent_q[i].busy && ent_q[i].qk != NO_Q) begin
        if (ent_q[i].qk == cdb0_des) begin
          ent_d[i].vk = cdb0_val; ent_d[i].qk = NO_Q;
        end else if (ent_q[i].qk == cdb1_des) begin
          ent_d[i].vk = cdb1_val; ent_d[i].qk = NO_Q;
        end
      end
    end

    new_e = '{busy: 1'b1, op: disp_op, vj: disp_vj, vk: disp_vk, qj: disp_qj,
              qk: disp_qk, des: disp_des, is_branch: disp_is_branch};
    if (disp_qj != NO_Q) begin
      if (disp_qj == cdb0_des) begin
        new_e.vj = cdb0_val; new_e.qj = NO_Q;
      end else if (disp_qj == cdb1_des) begin
        new_e.vj = cdb1_val; new_e.qj = NO_Q;
      end
    end
    if (disp_qk != NO_Q) begin
      if (disp_qk == cdb0_des) begin
        new_e.vk = cdb0_val; new_e.qk = NO_Q;
      end else if (disp_qk == cdb1_des) begin
        new_e.vk = cdb1_val; new_e.qk = NO_Q;
      end
    end

    alu_v1_d  = alu_v1_q;
    alu_v2_d  = alu_v2_q;
    alu_op_d  = alu_op_q;
    alu_des_d = alu_des_q;
    alu_br_d  = alu_br_q;

    if (!pause) begin
      if (rdy_found) begin
        alu_v1_d  = ent_q[rdy_idx].vj;
        alu_v2_d  = ent_q[rdy_idx].vk;
        alu_op_d  = ent_q[rdy_idx].op;
        alu_des_d = ent_q[rdy_idx].des;
        alu_br_d  = ent_q[rdy_idx].is_branch;
        ent_d[rdy_idx].busy = 1'b0;
      end else begin
        alu_v1_d  = '0;
        alu_v2_d  = '0;
        alu_op_d  = IDLE_OP;
        alu_des_d = NO_Q;
        alu_br_d  = 1'b0;
      end
      // The free slot is never the issuing one: it was not busy last cycle.
      if (disp_valid && free_found) begin
        ent_d[free_idx] = new_e;
      end
    end
  end

  // State registers; reset drops any dispatch presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      alu_v1_q  <= '0;
      alu_v2_q  <= '0;
      alu_op_q  <= IDLE_OP;
      alu_des_q <= NO_Q;
      alu_br_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      alu_v1_q  <= alu_v1_d;
      alu_v2_q  <= alu_v2_d;
      alu_op_q  <= alu_op_d;
      alu_des_q <= alu_des_d;
      alu_br_q  <= alu_br_d;
    end
  end

  assign alu_value_1   = alu_v1_q;
  assign alu_value_2   = alu_v2_q;
  assign alu_op        = alu_op_q;
  assign alu_des       = alu_des_q;
  assign alu_is_branch = alu_br_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench: directed scenarios then random traffic, all checked
// against a slot-list reference model evaluated once per clock edge.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  localparam int DEPTH = 4;
  localparam int TW    = 3;

  logic          clk = 1'b0;
  logic          rst, pause, disp_valid, disp_is_branch;
  logic [4:0]    disp_op;
  logic [31:0]   disp_vj, disp_vk, cdb0_val, cdb1_val;
  logic [TW-1:0] disp_qj, disp_qk, disp_des, cdb0_des, cdb1_des;
  logic          full, alu_is_branch;
  logic [31:0]   alu_value_1, alu_value_2;
  logic [4:0]    alu_op;
  logic [TW-1:0] alu_des;

  int n_vec = 0;
  int n_err = 0;

  alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .pause(pause), .disp_valid(disp_valid),
    .disp_op(disp_op), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_des(disp_des),
    .disp_is_branch(disp_is_branch), .full(full),
    .cdb0_des(cdb0_des), .cdb1_des(cdb1_des),
    .cdb0_val(cdb0_val), .cdb1_val(cdb1_val),
    .alu_value_1(alu_value_1), .alu_value_2(alu_value_2),
    .alu_op(alu_op), .alu_des(alu_des), .alu_is_branch(alu_is_branch)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          busy;
    logic [4:0]  op;
    logic [31:0] vj, vk;
    int          qj, qk;
    int          des;
    bit          br;
  } slot_t;

  slot_t       m [DEPTH];
  logic [31:0] e_v1, e_v2;
  logic [4:0]  e_op;
  int          e_des;
  bit          e_br;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // A waiting tag is satisfied by whichever bus carries it, bus 0 first.
  function automatic bit bus_hit(input int q, output logic [31:0] v);
    v = '0;
    if (q == 0) return 1'b0;
    if (q == int'(cdb0_des)) begin v = cdb0_val; return 1'b1; end
    if (q == int'(cdb1_des)) begin v = cdb1_val; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic void set_idle();
    e_v1 = 0; e_v2 = 0; e_op = IDLE_OP; e_des = 0; e_br = 0;
  endfunction

  // Apply one clock edge to the model using the inputs held across it.
  function automatic void model_edge();
    int          rd, fr;
    logic [31:0] v;
    slot_t       n;
    if (rst) begin
      foreach (m[i]) m[i] = '{0, 0, 0, 0, 0, 0, 0, 0};
      set_idle();
      return;
    end
    rd = -1; fr = -1;
    foreach (m[i]) begin
      if (rd < 0 && m[i].busy && m[i].qj == 0 && m[i].qk == 0) rd = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    foreach (m[i]) if (m[i].busy) begin
      if (bus_hit(m[i].qj, v)) begin m[i].vj = v; m[i].qj = 0; end
      if (bus_hit(m[i].qk, v)) begin m[i].vk = v; m[i].qk = 0; end
    end
    if (pause) return;
    if (rd >= 0) begin
      e_v1 = m[rd].vj; e_v2 = m[rd].vk; e_op = m[rd].op;
      e_des = m[rd].des; e_br = m[rd].br;
      m[rd].busy = 0;
    end else set_idle();
    if (disp_valid && fr >= 0) begin
      n = '{1, disp_op, disp_vj, disp_vk, int'(disp_qj), int'(disp_qk), int'(disp_des), disp_is_branch};
      if (bus_hit(n.qj, v)) begin n.vj = v; n.qj = 0; end
      if (bus_hit(n.qk, v)) begin n.vk = v; n.qk = 0; end
      m[fr] = n;
    end
  endfunction

  function automatic bit model_full();
    foreach (m[i]) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("value_1", alu_value_1, e_v1);
    chk("value_2", alu_value_2, e_v2);
    chk("op", 32'(alu_op), 32'(e_op));
    chk("des", 32'(alu_des), 32'(e_des));
    chk("is_branch", 32'(alu_is_branch), 32'(e_br));
    chk("full", 32'(full), 32'(model_full()));
  endtask

  task automatic disp(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                      input int qj, input int qk, input int des, input bit br);
    disp_valid = 1; disp_op = op; disp_vj = vj; disp_vk = vk;
    disp_qj = TW'(qj); disp_qk = TW'(qk); disp_des = TW'(des); disp_is_branch = br;
  endtask

  task automatic no_disp();
    disp_valid = 0; disp_op = 0; disp_vj = 0; disp_vk = 0;
    disp_qj = 0; disp_qk = 0; disp_des = 0; disp_is_branch = 0;
  endtask

  task automatic bus(input int d0, input logic [31:0] v0, input int d1, input logic [31:0] v1);
    cdb0_des = TW'(d0); cdb0_val = v0; cdb1_des = TW'(d1); cdb1_val = v1;
  endtask

  initial begin
    rst = 1; pause = 0; no_disp(); bus(0, 0, 0, 0);
    foreach (m[i]) m[i] = '{0, 0, 0, 0, 0, 0, 0, 0};
    set_idle();
    step(); step();
    chk("reset_op", 32'(alu_op), 32'(IDLE_OP));
    chk("reset_full", 32'(full), 0);
    rst = 0;

    // Ready-at-dispatch op issues on the next edge, then the port idles.
    disp(OP_ADD, 5, 7, 0, 0, 3, 0); step();
    no_disp(); step();
    chk("add_op", 32'(alu_op), 32'(OP_ADD));
    chk("add_v1", alu_value_1, 5);
    chk("add_v2", alu_value_2, 7);
    chk("add_des", 32'(alu_des), 3);
    step();
    chk("idle_des", 32'(alu_des), 0);

    // Operand arrives later on cdb0.
    disp(OP_SUB, 0, 9, 4, 0, 2, 0); step();
    no_disp(); step();
    bus(4, 100, 0, 0); step();
    bus(0, 0, 0, 0); step();
    chk("sub_v1", alu_value_1, 100);
    chk("sub_des", 32'(alu_des), 2);

    // Same-cycle bypass from cdb1.
    disp(OP_XOR, 1, 0, 0, 5, 4, 1); bus(0, 0, 5, 32'hDEADBEEF); step();
    no_disp(); bus(0, 0, 0, 0); step();
    chk("byp_v2", alu_value_2, 32'hDEADBEEF);
    chk("byp_br", 32'(alu_is_branch), 1);

    // Fill every slot waiting on tag 6; the fifth dispatch is dropped.
    for (int i = 0; i < DEPTH + 1; i++) begin
      disp(OP_OR, 32'(i), 32'(10 + i), 6, 0, i + 1, 0); step();
    end
    chk("fill_full", 32'(full), 1);
    no_disp(); bus(6, 77, 0, 0); step();
    bus(0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) step();

    // Pause with one ready slot and one capture in flight.
    disp(OP_AND, 1, 2, 7, 0, 1, 0); step();
    disp(OP_SLT, 3, 4, 0, 0, 5, 0); step();
    no_disp(); pause = 1; step();
    bus(7, 55, 0, 0); step();
    bus(0, 0, 0, 0); step();
    pause = 0; step(); step(); step();

    // Reset with busy slots and a live issue.
    for (int i = 0; i < 3; i++) begin
      disp(OP_ADD, 0, 0, 5, 0, i + 1, 0); step();
    end
    disp(OP_SUB, 8, 8, 0, 0, 7, 0); step();
    no_disp(); step();
    rst = 1; step();
    rst = 0;
    chk("rst_des", 32'(alu_des), 0);
    chk("rst_full", 32'(full), 0);
    bus(5, 1, 0, 0); step(); bus(0, 0, 0, 0); step(); step();

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      rst   = ($urandom_range(0, 99) == 0);
      pause = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 1)
        disp(5'($urandom_range(0, 16)), $urandom, $urandom,
             ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 7),
             ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 7),
             $urandom_range(1, 7), 1'($urandom_range(0, 1)));
      else no_disp();
      bus(($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 7), $urandom,
          ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 7), $urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
